// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the parametrised instruction memory:
//   - imem_state_e : clear-sequencer / run state encoding
//   - IMEM_NOP_WORD: default word driven when no valid instruction is present
//   - imem_index() : converts a fetch/programming address into a word index
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } imem_state_e;

  // Index arithmetic is done at this fixed width so any ADDR_W up to 64
  // zero-extends cleanly and the range compare never truncates.
  localparam int IDX_W = 64;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  function automatic logic [IDX_W-1:0] imem_index(input logic [IDX_W-1:0] addr,
                                                  input logic             byte_addr);
    return byte_addr ? (addr >> 2) : addr;
  endfunction

endpackage

// File: rtl/instr_mem_param_if.sv
// -----------------------------------------------------------------------------
// instr_mem_param_if
// Fetch and programming bus of the instruction memory.
//   master : fetch stage / loader (drives requests, receives instr and status)
//   slave  : instruction memory
// Signals:
//   fetch_addr, fetch_en, stall, flush          fetch request and pipeline control
//   instr, instr_valid, addr_fault              registered fetch result
//   init_done                                   clear sequence finished
//   prog_valid, prog_ready, prog_addr, prog_data programming write handshake
//   prog_err                                    dropped out-of-range write pulse
// -----------------------------------------------------------------------------
interface instr_mem_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_en;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  logic              init_done;
  logic              prog_valid;
  logic              prog_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;

  modport master (
    output fetch_addr, fetch_en, stall, flush,
    output prog_valid, prog_addr, prog_data,
    input  instr, instr_valid, addr_fault, init_done, prog_ready, prog_err
  );

  modport slave (
    input  fetch_addr, fetch_en, stall, flush,
    input  prog_valid, prog_addr, prog_data,
    output instr, instr_valid, addr_fault, init_done, prog_ready, prog_err
  );

endinterface

// File: rtl/imem_ram_1r1w.sv
// -----------------------------------------------------------------------------
// imem_ram_1r1w
// DEPTH x DATA_W array, one synchronous write port and one synchronous read
// port. Read-first: a read and write of the same word on the same edge returns
// the old contents. rdata holds its value whenever re is low.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read enable / address
//   rdata          registered read data
// -----------------------------------------------------------------------------
module imem_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_param.sv
// -----------------------------------------------------------------------------
// instr_mem_param
// Parametrised instruction memory with a 1-cycle fetch port (stall/flush),
// a valid/ready programming port and a post-reset clear sequencer.
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_mem_param_if.slave (fetch, programming and status signals)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_cnt] each cycle; fetches and writes refused
// ST_RUN   | memory usable; fetch port and programming port active
// -----------------------------------------------------------------------------
module instr_mem_param
  import imem_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 64,
  parameter int              ADDR_W    = 32,
  parameter bit              BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_param_if.slave   bus
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [AW-1:0]    CLR_LAST  = AW'(DEPTH - 1);

  imem_state_e       state, state_nxt;
  logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
  logic              run;

  logic [IDX_W-1:0]  fetch_idx, prog_idx;
  logic              fetch_in_range, prog_in_range, prog_acc;

  logic              we, re;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata, rdata;

  logic              valid_q, fault_q, err_q;

  assign run            = (state == ST_RUN);
  assign fetch_idx      = imem_index(IDX_W'(bus.fetch_addr), BYTE_ADDR);
  assign prog_idx       = imem_index(IDX_W'(bus.prog_addr), BYTE_ADDR);
  assign fetch_in_range = (fetch_idx < DEPTH_IDX);
  assign prog_in_range  = (prog_idx < DEPTH_IDX);
  assign prog_acc       = bus.prog_valid && run;

  // Clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_nxt = clr_cnt + AW'(1);
      if (clr_cnt == CLR_LAST) begin
        state_nxt   = ST_RUN;
        clr_cnt_nxt = '0;
      end
    end
  end

  // The sequencer owns the write port during CLEAR; afterwards it belongs to
  // the programming port. Out-of-range writes never reach the array.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!run) begin
      we    = 1'b1;
      waddr = clr_cnt;
    end else if (prog_acc && prog_in_range) begin
      we    = 1'b1;
      waddr = prog_idx[AW-1:0];
      wdata = bus.prog_data;
    end
  end

  // The RAM read register doubles as the instr data register: it is only
  // loaded on an in-range fetch that wins priority, so it holds under stall.
  assign re = run && !bus.flush && !bus.stall && bus.fetch_en && fetch_in_range;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_idx[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= prog_acc && !prog_in_range;
      if (!run || bus.flush) begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
      end else if (bus.stall) begin
        valid_q <= valid_q;
        fault_q <= fault_q;
      end else if (bus.fetch_en) begin
        valid_q <= fetch_in_range;
        fault_q <= !fetch_in_range;
      end else begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
      end
    end
  end

  // rdata is never reset; masking with valid_q gives NOP_WORD out of reset.
  assign bus.instr       = valid_q ? rdata : NOP_WORD;
  assign bus.instr_valid = valid_q;
  assign bus.addr_fault  = fault_q;
  assign bus.prog_err    = err_q;
  assign bus.prog_ready  = run;
  assign bus.init_done   = run;

endmodule

// File: tb/tb_instr_mem_param.sv
module tb_instr_mem_param;

  localparam int DEPTH   = 64;
  localparam int B_DEPTH = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_param_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
  instr_mem_param_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

  instr_mem_param #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(1'b1), .NOP_WORD(32'h0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );

  instr_mem_param #(
    .DATA_W(32), .DEPTH(B_DEPTH), .ADDR_W(32), .BYTE_ADDR(1'b0), .NOP_WORD(32'h0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of dut_a: clear phase is "the first DEPTH edges after
  // reset", memory is a plain word array, addresses are divided by 4.
  logic [31:0] mem_m [DEPTH];
  int          edges;
  logic [31:0] e_instr;
  logic        e_valid, e_fault, e_err;

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned idx;
    int unsigned pidx;
    if (!rst_n) begin
      edges   = 0;
      e_instr = 32'h0;
      e_valid = 1'b0;
      e_fault = 1'b0;
      e_err   = 1'b0;
    end else if (edges < DEPTH) begin
      edges++;
      e_instr = 32'h0;
      e_valid = 1'b0;
      e_fault = 1'b0;
      e_err   = 1'b0;
      if (edges == DEPTH) foreach (mem_m[i]) mem_m[i] = 32'h0;
    end else begin
      idx   = a_if.fetch_addr / 4;
      pidx  = a_if.prog_addr / 4;
      e_err = 1'b0;
      if (a_if.flush) begin
        e_instr = 32'h0; e_valid = 1'b0; e_fault = 1'b0;
      end else if (a_if.stall) begin
        // hold
      end else if (a_if.fetch_en) begin
        if (idx < DEPTH) begin
          e_instr = mem_m[idx]; e_valid = 1'b1; e_fault = 1'b0;
        end else begin
          e_instr = 32'h0; e_valid = 1'b0; e_fault = 1'b1;
        end
      end else begin
        e_instr = 32'h0; e_valid = 1'b0; e_fault = 1'b0;
      end
      // read above happens before the write: read-first
      if (a_if.prog_valid) begin
        if (pidx < DEPTH) mem_m[pidx] = a_if.prog_data;
        else              e_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk32("cmp_instr", a_if.instr, e_instr);
      chk1("cmp_valid", a_if.instr_valid, e_valid);
      chk1("cmp_fault", a_if.addr_fault, e_fault);
      chk1("cmp_err",   a_if.prog_err, e_err);
      chk1("cmp_init",  a_if.init_done, edges >= DEPTH);
      chk1("cmp_ready", a_if.prog_ready, edges >= DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.fetch_addr = '0; a_if.fetch_en = 1'b0; a_if.stall = 1'b0; a_if.flush = 1'b0;
    a_if.prog_valid = 1'b0; a_if.prog_addr = '0; a_if.prog_data = '0;
  endtask

  task automatic idle_b();
    b_if.fetch_addr = '0; b_if.fetch_en = 1'b0; b_if.stall = 1'b0; b_if.flush = 1'b0;
    b_if.prog_valid = 1'b0; b_if.prog_addr = '0; b_if.prog_data = '0;
  endtask

  task automatic a_fetch(input logic [31:0] addr);
    a_if.fetch_en = 1'b1; a_if.fetch_addr = addr;
    tick();
    a_if.fetch_en = 1'b0;
  endtask

  task automatic a_prog(input logic [31:0] addr, input logic [31:0] data);
    a_if.prog_valid = 1'b1; a_if.prog_addr = addr; a_if.prog_data = data;
    tick();
    a_if.prog_valid = 1'b0;
  endtask

  task automatic b_fetch(input logic [31:0] addr);
    b_if.fetch_en = 1'b1; b_if.fetch_addr = addr;
    tick();
    b_if.fetch_en = 1'b0;
  endtask

  task automatic b_prog(input logic [31:0] addr, input logic [31:0] data);
    b_if.prog_valid = 1'b1; b_if.prog_addr = addr; b_if.prog_data = data;
    tick();
    b_if.prog_valid = 1'b0;
  endtask

  initial begin
    idle_a();
    idle_b();
    tick();
    cmp_en = 1'b1;
    tick();

    // reset values
    chk32("rst_instr", a_if.instr, 32'h0);
    chk1("rst_valid", a_if.instr_valid, 1'b0);
    chk1("rst_fault", a_if.addr_fault, 1'b0);
    chk1("rst_init",  a_if.init_done, 1'b0);
    chk1("rst_ready", a_if.prog_ready, 1'b0);
    chk1("rst_err",   a_if.prog_err, 1'b0);

    // clear phase: fetches requested throughout are ignored
    a_if.fetch_en = 1'b1; a_if.fetch_addr = 32'h10;
    rst_n = 1'b1;
    repeat (63) tick();
    chk1("clr63_init",  a_if.init_done, 1'b0);
    chk1("clr63_ready", a_if.prog_ready, 1'b0);
    chk1("clr63_valid", a_if.instr_valid, 1'b0);
    tick();
    chk1("clr64_init",  a_if.init_done, 1'b1);
    chk1("clr64_ready", a_if.prog_ready, 1'b1);
    chk1("clr64_valid", a_if.instr_valid, 1'b0);
    tick();
    chk32("run_fetch10_instr", a_if.instr, 32'h0);
    chk1("run_fetch10_valid", a_if.instr_valid, 1'b1);
    idle_a();

    // programming then fetch
    a_prog(32'h00, 32'h1111_2222);
    a_prog(32'h04, 32'hAAA0_000C);
    a_prog(32'h08, 32'h8B0A_012B);
    a_fetch(32'h04);
    chk32("fetch04", a_if.instr, 32'hAAA0_000C);
    chk1("fetch04_valid", a_if.instr_valid, 1'b1);
    a_fetch(32'h08);
    chk32("fetch08", a_if.instr, 32'h8B0A_012B);

    // out-of-range fetch and write (idx 64 aliases idx 0 if truncated)
    a_fetch(32'h100);
    chk1("oor_fault", a_if.addr_fault, 1'b1);
    chk1("oor_valid", a_if.instr_valid, 1'b0);
    chk32("oor_instr", a_if.instr, 32'h0);
    a_prog(32'h100, 32'hDEAD_BEEF);
    chk1("oor_err_pulse", a_if.prog_err, 1'b1);
    tick();
    chk1("oor_err_low", a_if.prog_err, 1'b0);
    a_fetch(32'h00);
    chk32("fetch00_kept", a_if.instr, 32'h1111_2222);

    // stall holds output; a write during stall still lands
    a_if.fetch_en = 1'b1; a_if.fetch_addr = 32'h04;
    tick();
    chk32("pre_stall", a_if.instr, 32'hAAA0_000C);
    a_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.fetch_addr = 32'h08 + 32'(4 * i);
      a_if.prog_valid = (i == 1);
      a_if.prog_addr  = 32'h10;
      a_if.prog_data  = 32'h5555_AAAA;
      tick();
      chk32("stall_hold", a_if.instr, 32'hAAA0_000C);
      chk1("stall_valid", a_if.instr_valid, 1'b1);
    end
    a_if.prog_valid = 1'b0;
    a_if.flush = 1'b1;
    tick();
    chk1("flush_valid", a_if.instr_valid, 1'b0);
    chk32("flush_instr", a_if.instr, 32'h0);
    idle_a();
    a_fetch(32'h10);
    chk32("stall_write", a_if.instr, 32'h5555_AAAA);

    // same-cycle write and fetch: read-first
    a_if.prog_valid = 1'b1; a_if.prog_addr = 32'h0C; a_if.prog_data = 32'h1234_5678;
    a_if.fetch_en = 1'b1; a_if.fetch_addr = 32'h0C;
    tick();
    chk32("rf_old", a_if.instr, 32'h0);
    a_if.prog_valid = 1'b0;
    tick();
    chk32("rf_new", a_if.instr, 32'h1234_5678);
    idle_a();

    // async reset from RUN, then reset again mid-clear
    a_fetch(32'h04);
    chk1("prerst_valid", a_if.instr_valid, 1'b1);
    a_if.fetch_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("arst_valid", a_if.instr_valid, 1'b0);
    chk32("arst_instr", a_if.instr, 32'h0);
    chk1("arst_init", a_if.init_done, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk1("mid_init", a_if.init_done, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_init", a_if.init_done, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (63) tick();
    chk1("reclr63_init", a_if.init_done, 1'b0);
    tick();
    chk1("reclr64_init", a_if.init_done, 1'b1);
    idle_a();
    a_fetch(32'h04);
    chk32("recleared04", a_if.instr, 32'h0);
    chk1("recleared04_valid", a_if.instr_valid, 1'b1);

    // word addressing, non power-of-two depth
    chk1("b_init", b_if.init_done, 1'b1);
    b_prog(32'd3, 32'hCAFE_0003);
    b_prog(32'd9, 32'h0000_0099);
    b_fetch(32'd3);
    chk32("b_fetch3", b_if.instr, 32'hCAFE_0003);
    chk1("b_fetch3_valid", b_if.instr_valid, 1'b1);
    b_fetch(32'd9);
    chk32("b_fetch9", b_if.instr, 32'h0000_0099);
    b_fetch(32'd10);
    chk1("b_fetch10_fault", b_if.addr_fault, 1'b1);
    chk1("b_fetch10_valid", b_if.instr_valid, 1'b0);
    b_prog(32'd10, 32'hFFFF_FFFF);
    chk1("b_prog10_err", b_if.prog_err, 1'b1);
    b_fetch(32'd2);
    chk32("b_fetch2", b_if.instr, 32'h0);
    chk1("b_fetch2_err_low", b_if.prog_err, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_param.md
Name: instr_mem_param

Overview:
Parametrised instruction memory for the LEGv8 datapath and successor to the fixed 64x32 instruction ROM.
- Synchronous 1-cycle fetch port with stall and flush for the pipelined core.
- Run-time programming port with a valid/ready handshake, replacing hard-coded initial contents.
- Post-reset clear sequencer that zeroes the array.
- Out-of-range fetch detection, with NOP substitution on a fault.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 64, number of words; need not be a power of two; must be >= 2
ADDR_W, 32, width of fetch and programming address buses
BYTE_ADDR, 1, 1 = addresses are byte addresses (word index = addr>>2); 0 = addresses are word indices
NOP_WORD, 0, value driven on instr when there is no valid instruction

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_addr  in  ADDR_W  PC from the fetch stage
fetch_en  in  1  request a fetch this cycle
stall  in  1  hold instr/instr_valid/addr_fault unchanged
flush  in  1  kill the output register
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr holds a real fetched word
addr_fault  out  1  registered; last fetch was out of range
init_done  out  1  clear sequence complete; memory usable
prog_valid  in  1  programming write request
prog_ready  out  1  programming write can be accepted
prog_addr  in  ADDR_W  programming address, same addressing mode as fetch
prog_data  in  DATA_W  word to write
prog_err  out  1  1-cycle pulse: accepted write was out of range and was dropped

Behaviour:
- Reset (async, rst_n=0): instr=NOP_WORD, instr_valid=0, addr_fault=0, init_done=0, prog_err=0, FSM=CLEAR, clr_cnt=0. The array itself is not reset.
- Index calculation: idx = BYTE_ADDR ? addr[ADDR_W-1:2] : addr. A fetch or write is in range iff idx < DEPTH. The low two bits are ignored when BYTE_ADDR=1.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt == DEPTH-1, that word is written and the FSM moves to RUN.
  - CLEAR lasts exactly DEPTH cycles; init_done rises on the first RUN cycle.
  - While in CLEAR: prog_ready=0; instr_valid=0 and instr=NOP_WORD (fetches are ignored).
- FSM RUN: stays in RUN until reset. Reset mid-CLEAR restarts the sequence from clr_cnt=0.
- prog_ready = (FSM==RUN), combinational from state only.
- Programming write, accepted when prog_valid && prog_ready:
  - In range: write prog_data to mem[idx] at this edge.
  - Out of range: no write; prog_err=1 on the next cycle.
- Output register update priority, first match wins:
  1. flush: instr=NOP_WORD, instr_valid=0, addr_fault=0. Flush beats stall.
  2. stall: all three outputs hold.
  3. fetch_en, in range: instr=mem[idx], instr_valid=1, addr_fault=0. Latency is 1 cycle.
  4. fetch_en, out of range: instr=NOP_WORD, instr_valid=0, addr_fault=1.
  5. Otherwise: instr=NOP_WORD, instr_valid=0, addr_fault=0.
- A fetch and a programming write to the same idx in the same cycle is read-first: instr gets the old word, and the new word is visible to fetches from the next cycle on.
- A write issued during a stall still lands in the array; the held instr is unaffected.

Decomposition:
- Shared package imem_pkg holds:
  - FSM state encoding: ST_CLEAR, ST_RUN.
  - Default NOP_WORD constant.
  - Function imem_index(addr, byte_addr) returning the word index.
- One sub-module, imem_ram_1r1w: DEPTH x DATA_W array with one synchronous read port and one synchronous write port, read-first. Write-port muxing between the clear sequencer and the programming port stays in instr_mem_param.

Test Plan:
- Reset then idle, DEPTH=64 -> init_done=0 and prog_ready=0 for 64 cycles, both 1 from cycle 64; fetches during CLEAR give instr_valid=0; after CLEAR, fetch of addr 0x10 returns 0.
- Program addr 0x04=0xAAA0000C and 0x08=0x8B0A012B, then fetch 0x04, 0x08 -> instr=0xAAA0000C then 0x8B0A012B, instr_valid=1 one cycle after each fetch_en.
- Fetch 0x100 with DEPTH=64 (idx 64) -> addr_fault=1, instr=NOP_WORD, instr_valid=0; prog write to 0x100 -> prog_err pulses for exactly 1 cycle, and a later fetch of 0x00 still returns its prior value.
- Fetch 0x04 (valid), then stall=1 for 3 cycles while fetch_addr changes -> instr held at mem[1]; flush=1 together with stall=1 -> instr_valid=0 next cycle.
- Same cycle: write 0x12345678 to 0x0C and fetch 0x0C -> old value returned; fetch 0x0C next cycle -> 0x12345678.
- Assert rst_n=0 mid-CLEAR (cycle 20) -> outputs return to reset values immediately; CLEAR then lasts the full 64 cycles again. With BYTE_ADDR=0, fetch addr 3 -> mem[3].
